fifo_serial_tx: RTL and testbench

- Read-side consumer for the team's synchronous FIFO. Drains one word at a time and transmits it as an asynchronous serial frame: start bit, data LSB-first, optional parity, stop bit.
- Sits between the FIFO read port and an off-chip serial line.
- Drives the FIFO's read-enable and obeys its registered-read timing: read data is valid on the clock edge after the one that samples read-enable.

---
 rtl/fifo_serial_tx_pkg.sv | 30 +++
 rtl/fifo_serial_tx_if.sv | 34 +++
 rtl/fifo_serial_tx_baud.sv | 29 ++
 rtl/fifo_serial_tx.sv | 157 +++++++++++++++
 tb/tb_fifo_serial_tx.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and constants for the FIFO-to-serial transmitter.
// Holds the FSM state encoding, line levels and a frame-length helper.
// FIFO_SERIAL_TX_PARITY_EN adds the PARITY state and one extra bit per frame.
package fifo_serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        LATCH  = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
`ifdef FIFO_SERIAL_TX_PARITY_EN
        PARITY = 3'd5,
`endif
        STOP   = 3'd6
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Clock cycles from the first start-bit cycle to the last stop-bit cycle.
    function automatic int frame_cycles(input int word_w, input int clks_per_bit);
`ifdef FIFO_SERIAL_TX_PARITY_EN
        return (word_w + 3) * clks_per_bit;
`else
        return (word_w + 2) * clks_per_bit;
`endif
    endfunction

endpackage

// File: rtl/fifo_serial_tx_if.sv
// Bundle between the FIFO read port, the enable source and the serial line.
// master: the transmitter (drives fifo_rd_en, tx, busy, word_done).
// slave: the environment (drives fifo_data, fifo_empty, tx_en).
interface fifo_serial_tx_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] fifo_data;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic              tx_en;
    logic              tx;
    logic              busy;
    logic              word_done;

    modport master (
        input  fifo_data,
        input  fifo_empty,
        input  tx_en,
        output fifo_rd_en,
        output tx,
        output busy,
        output word_done
    );

    modport slave (
        output fifo_data,
        output fifo_empty,
        output tx_en,
        input  fifo_rd_en,
        input  tx,
        input  busy,
        input  word_done
    );
endinterface

// File: rtl/fifo_serial_tx_baud.sv
// Bit-period counter: bit_tick pulses on the last clk of every serial bit.
// Ports: clk, rst (async, active-high), clr (restart the period), bit_tick.
// No backpressure; CLKS_PER_BIT must be 2 or more.
module fifo_serial_tx_baud #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_tick
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/fifo_serial_tx.sv
// Drains a registered-read FIFO one word at a time onto an async serial line
// (start, WORD_W data bits LSB-first, optional even parity, stop).
// Latency: read pulse -> start bit in 2 clks; frame (WORD_W+2)*CLKS_PER_BIT clks.
// Backpressure: only reads when tx_en=1 and fifo_empty=0 in IDLE; a started frame always completes.
// Ports: clk, rst (async, active-high), bus (fifo_serial_tx_if.master).
// Macro FIFO_SERIAL_TX_PARITY_EN inserts a PARITY bit between DATA and STOP.
module fifo_serial_tx
    import fifo_serial_tx_pkg::*;
#(
    parameter int WORD_W       = 16,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    fifo_serial_tx_if.master bus
);
    localparam int IDX_W = $clog2(WORD_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] shift_reg;
    logic [WORD_W-1:0] shift_nxt;
    logic [IDX_W-1:0]  bit_idx;
    logic [IDX_W-1:0]  bit_idx_nxt;
    logic              tx_q;
    logic              tx_d;
    logic              rd_en_q;
    logic              rd_en_d;
    logic              done_q;
    logic              done_d;
    logic              bit_tick;
    logic              baud_clr;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    logic              parity_q;
`endif

    fifo_serial_tx_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (baud_clr),
        .bit_tick (bit_tick)
    );

    // State register plus registered outputs; tx resets high asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            tx_q      <= IDLE_LEVEL;
            rd_en_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_idx   <= bit_idx_nxt;
            tx_q      <= tx_d;
            rd_en_q   <= rd_en_d;
            done_q    <= done_d;
        end
    end

`ifdef FIFO_SERIAL_TX_PARITY_EN
    // Parity is taken from the whole word at capture time, since the shift
    // register no longer holds it by the time the parity bit goes out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (state == LATCH) begin
            parity_q <= ^bus.fifo_data;
        end
    end
`endif

    // Next-state and datapath update.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_reg;
        bit_idx_nxt = bit_idx;
        case (state)
            IDLE: begin
                if (bus.tx_en && !bus.fifo_empty) begin
                    state_nxt = REQ;
                end
            end
            // The FIFO samples fifo_rd_en on the edge leaving REQ; its data
            // is valid during LATCH.
            REQ: begin
                state_nxt = LATCH;
            end
            LATCH: begin
                state_nxt = START;
                shift_nxt = bus.fifo_data;
            end
            START: begin
                if (bit_tick) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_nxt   = shift_reg >> 1;
                    bit_idx_nxt = bit_idx + IDX_W'(1);
                    if (bit_idx == LAST_IDX) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef FIFO_SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are computed from the upcoming state so that the registered
    // copies line up with the state they belong to.
    always_comb begin
        baud_clr = (state == LATCH);
        rd_en_d  = (state == IDLE) && (state_nxt == REQ);
        done_d   = (state == STOP) && bit_tick;
        tx_d     = IDLE_LEVEL;
        case (state_nxt)
            START:   tx_d = START_LEVEL;
            DATA:    tx_d = shift_nxt[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = IDLE_LEVEL;
        endcase
    end

    assign bus.tx         = tx_q;
    assign bus.fifo_rd_en = rd_en_q;
    assign bus.word_done  = done_q;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx with WORD_W=16, CLKS_PER_BIT=4.
// A registered-read FIFO model feeds the DUT; tx/rd/busy/done are traced
// once per cycle on the falling edge and each test decodes the trace.
module tb_fifo_serial_tx;
    localparam int WORD_W = 16;
    localparam int CPB    = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    localparam int PBITS  = 1;
`else
    localparam int PBITS  = 0;
`endif
    localparam int FRAME    = (WORD_W + 2 + PBITS) * CPB;
    localparam int STOP_OFS = (1 + WORD_W + PBITS) * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_serial_tx_if #(.WORD_W(WORD_W)) bus ();

    fifo_serial_tx #(
        .WORD_W       (WORD_W),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] fq[$];
    logic [15:0] rd_word;
    bit          rd_pending = 1'b0;
    logic        tr_tx[$];
    logic        tr_rd[$];
    logic        tr_busy[$];
    logic        tr_done[$];

    task automatic push_word(input logic [15:0] w);
        fq.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    task automatic clear_trace();
        tr_tx.delete();
        tr_rd.delete();
        tr_busy.delete();
        tr_done.delete();
    endtask

    // One iteration per clk; the FIFO model reads on the edge after the
    // falling edge that saw fifo_rd_en, and presents data after that edge.
    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (rd_pending) begin
                bus.fifo_data  = rd_word;
                rd_pending     = 1'b0;
                bus.fifo_empty = (fq.size() == 0);
            end
            @(negedge clk);
            tr_tx.push_back(bus.tx);
            tr_rd.push_back(bus.fifo_rd_en);
            tr_busy.push_back(bus.busy);
            tr_done.push_back(bus.word_done);
            if (bus.fifo_rd_en === 1'b1 && fq.size() > 0) begin
                rd_word    = fq.pop_front();
                rd_pending = 1'b1;
            end
        end
    endtask

    function automatic int find_low(input int from);
        for (int i = from; i < tr_tx.size(); i++) begin
            if (tr_tx[i] === 1'b0) return i;
        end
        return -1;
    endfunction

    function automatic int find_done(input int from);
        for (int i = from; i < tr_done.size(); i++) begin
            if (tr_done[i] === 1'b1) return i;
        end
        return -1;
    endfunction

    // sel: 0 tx, 1 rd, 2 busy, 3 done
    function automatic int count_level(input int sel, input logic lvl);
        int n = 0;
        for (int i = 0; i < tr_tx.size(); i++) begin
            logic v;
            case (sel)
                0:       v = tr_tx[i];
                1:       v = tr_rd[i];
                2:       v = tr_busy[i];
                default: v = tr_done[i];
            endcase
            if (v === lvl) n++;
        end
        return n;
    endfunction

    // Decodes the frame whose start bit begins at s; bad counts cycles that
    // deviate from a clean start/data/stop shape.
    task automatic decode_frame(input int s, output logic [15:0] w, output int bad);
        bad = 0;
        w   = 'x;
        if (s < 0 || s + FRAME > tr_tx.size()) begin
            bad = 1;
            return;
        end
        for (int k = 0; k < CPB; k++) if (tr_tx[s + k] !== 1'b0) bad++;
        for (int b = 0; b < WORD_W; b++) begin
            w[b] = tr_tx[s + CPB * (b + 1)];
            for (int k = 0; k < CPB; k++) begin
                if (tr_tx[s + CPB * (b + 1) + k] !== w[b]) bad++;
            end
        end
        for (int k = 0; k < CPB; k++) if (tr_tx[s + STOP_OFS + k] !== 1'b1) bad++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.tx_en      = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = '0;
        run_cycles(3);
        tests_run++;
        if (bus.tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b expected 1", bus.tx); end
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests_run++;
        if (bus.fifo_rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_en: got %b expected 0", bus.fifo_rd_en); end
        tests_run++;
        if (bus.word_done !== 1'b0) begin tests_failed++; $display("FAIL reset_word_done: got %b expected 0", bus.word_done); end
        rst = 1'b0;
        run_cycles(2);
    endtask

    task automatic test_reset_mid_data();
        clear_trace();
        push_word(16'h0000);
        bus.tx_en = 1'b1;
        run_cycles(12);
        tests_run++;
        if (tr_busy[11] !== 1'b1 || tr_tx[11] !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_pre_reset: busy=%b tx=%b expected busy=1 tx=0", tr_busy[11], tr_tx[11]);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (bus.tx !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_tx: got %b expected 1", bus.tx); end
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_busy: got %b expected 0", bus.busy); end
        @(negedge clk);
        tests_run++;
        if (bus.fifo_rd_en !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_rd_en: got %b expected 0", bus.fifo_rd_en); end
        tests_run++;
        if (bus.word_done !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_word_done: got %b expected 0", bus.word_done); end
        rst = 1'b0;
        clear_trace();
        run_cycles(40);
        tests_run++;
        if (count_level(3, 1'b1) != 0) begin tests_failed++; $display("FAIL mid_reset_no_done: got %0d pulses expected 0", count_level(3, 1'b1)); end
        tests_run++;
        if (count_level(0, 1'b0) != 0) begin tests_failed++; $display("FAIL mid_reset_no_retx: got %0d low cycles expected 0", count_level(0, 1'b0)); end
        tests_run++;
        if (count_level(2, 1'b1) != 0) begin tests_failed++; $display("FAIL mid_reset_idle: got %0d busy cycles expected 0", count_level(2, 1'b1)); end
        bus.tx_en = 1'b0;
    endtask

    task automatic test_single_word();
        logic [15:0] w;
        int bad, s, d;
        clear_trace();
        push_word(16'hA5C3);
        bus.tx_en = 1'b1;
        run_cycles(FRAME + 12);
        bus.tx_en = 1'b0;
        s = find_low(0);
        d = find_done(0);
        decode_frame(s, w, bad);
        tests_run++;
        if (count_level(1, 1'b1) != 1) begin tests_failed++; $display("FAIL single_rd_pulses: got %0d expected 1", count_level(1, 1'b1)); end
        tests_run++;
        if (s != 2) begin tests_failed++; $display("FAIL single_start_index: got %0d expected 2", s); end
        tests_run++;
        if (w !== 16'hA5C3) begin tests_failed++; $display("FAIL single_word: got %h expected a5c3", w); end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL single_shape: got %0d bad cycles expected 0", bad); end
        tests_run++;
        if (d != s + FRAME) begin tests_failed++; $display("FAIL single_frame_len: got %0d expected %0d", d - s, FRAME); end
        tests_run++;
        if (count_level(3, 1'b1) != 1) begin tests_failed++; $display("FAIL single_done_pulses: got %0d expected 1", count_level(3, 1'b1)); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w1, w2;
        int bad1, bad2, s1, s2;
        clear_trace();
        push_word(16'h0001);
        push_word(16'hFFFF);
        bus.tx_en = 1'b1;
        run_cycles(2 * FRAME + 20);
        bus.tx_en = 1'b0;
        s1 = find_low(0);
        s2 = (s1 < 0) ? -1 : find_low(s1 + FRAME);
        decode_frame(s1, w1, bad1);
        decode_frame(s2, w2, bad2);
        tests_run++;
        if (count_level(1, 1'b1) != 2) begin tests_failed++; $display("FAIL b2b_rd_pulses: got %0d expected 2", count_level(1, 1'b1)); end
        tests_run++;
        if (s2 - (s1 + STOP_OFS) != CPB + 3) begin tests_failed++; $display("FAIL b2b_gap: got %0d expected %0d", s2 - (s1 + STOP_OFS), CPB + 3); end
        tests_run++;
        if (w1 !== 16'h0001 || bad1 != 0) begin tests_failed++; $display("FAIL b2b_word1: got %h bad=%0d expected 0001 bad=0", w1, bad1); end
        tests_run++;
        if (w2 !== 16'hFFFF || bad2 != 0) begin tests_failed++; $display("FAIL b2b_word2: got %h bad=%0d expected ffff bad=0", w2, bad2); end
    endtask

    task automatic test_empty();
        clear_trace();
        bus.tx_en = 1'b1;
        run_cycles(100);
        bus.tx_en = 1'b0;
        tests_run++;
        if (count_level(1, 1'b1) != 0) begin tests_failed++; $display("FAIL empty_rd: got %0d pulses expected 0", count_level(1, 1'b1)); end
        tests_run++;
        if (count_level(0, 1'b0) != 0) begin tests_failed++; $display("FAIL empty_tx: got %0d low cycles expected 0", count_level(0, 1'b0)); end
        tests_run++;
        if (count_level(2, 1'b1) != 0) begin tests_failed++; $display("FAIL empty_busy: got %0d busy cycles expected 0", count_level(2, 1'b1)); end
    endtask

    task automatic test_tx_en_drop();
        logic [15:0] w;
        int bad, s;
        clear_trace();
        push_word(16'h1234);
        push_word(16'h5678);
        bus.tx_en = 1'b1;
        run_cycles(25);
        bus.tx_en = 1'b0;
        run_cycles(FRAME + 40);
        s = find_low(0);
        decode_frame(s, w, bad);
        tests_run++;
        if (w !== 16'h1234 || bad != 0) begin tests_failed++; $display("FAIL drop_word1: got %h bad=%0d expected 1234 bad=0", w, bad); end
        tests_run++;
        if (count_level(1, 1'b1) != 1) begin tests_failed++; $display("FAIL drop_rd_pulses: got %0d expected 1", count_level(1, 1'b1)); end
        tests_run++;
        if (fq.size() != 1) begin tests_failed++; $display("FAIL drop_queue_left: got %0d expected 1", fq.size()); end
        tests_run++;
        if (tr_busy[tr_busy.size() - 1] !== 1'b0) begin tests_failed++; $display("FAIL drop_idle_hold: got busy=%b expected 0", tr_busy[tr_busy.size() - 1]); end
        clear_trace();
        bus.tx_en = 1'b1;
        run_cycles(FRAME + 12);
        bus.tx_en = 1'b0;
        s = find_low(0);
        decode_frame(s, w, bad);
        tests_run++;
        if (w !== 16'h5678 || bad != 0) begin tests_failed++; $display("FAIL drop_word2: got %h bad=%0d expected 5678 bad=0", w, bad); end
        tests_run++;
        if (count_level(1, 1'b1) != 1) begin tests_failed++; $display("FAIL drop_resume_rd: got %0d expected 1", count_level(1, 1'b1)); end
    endtask

    task automatic test_tx_en_glitch();
        logic [15:0] w;
        int bad, s;
        clear_trace();
        push_word(16'h00F0);
        bus.tx_en = 1'b1;
        run_cycles(1);
        bus.tx_en = 1'b0;
        run_cycles(FRAME + 10);
        s = find_low(0);
        decode_frame(s, w, bad);
        tests_run++;
        if (w !== 16'h00F0 || bad != 0) begin tests_failed++; $display("FAIL glitch_word: got %h bad=%0d expected 00f0 bad=0", w, bad); end
        tests_run++;
        if (count_level(1, 1'b1) != 1) begin tests_failed++; $display("FAIL glitch_rd_pulses: got %0d expected 1", count_level(1, 1'b1)); end
    endtask

`ifdef FIFO_SERIAL_TX_PARITY_EN
    task automatic test_parity();
        logic [15:0] w;
        logic [15:0] words [2];
        logic        exp_par [2];
        int bad, s, d, pofs;
        words[0] = 16'h0007; exp_par[0] = 1'b1;
        words[1] = 16'h0003; exp_par[1] = 1'b0;
        pofs = CPB * (WORD_W + 1);
        for (int t = 0; t < 2; t++) begin
            clear_trace();
            push_word(words[t]);
            bus.tx_en = 1'b1;
            run_cycles(FRAME + 12);
            bus.tx_en = 1'b0;
            s = find_low(0);
            d = find_done(0);
            decode_frame(s, w, bad);
            tests_run++;
            if (w !== words[t] || bad != 0) begin tests_failed++; $display("FAIL parity_word%0d: got %h bad=%0d expected %h", t, w, bad, words[t]); end
            for (int k = 0; k < CPB; k++) begin
                tests_run++;
                if (s < 0 || tr_tx[s + pofs + k] !== exp_par[t]) begin
                    tests_failed++;
                    $display("FAIL parity_bit%0d: cycle %0d expected %b", t, k, exp_par[t]);
                end
            end
            tests_run++;
            if (d - s != 76) begin tests_failed++; $display("FAIL parity_frame_len%0d: got %0d expected 76", t, d - s); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_data();
        test_single_word();
        test_back_to_back();
        test_empty();
        test_tx_en_drop();
        test_tx_en_glitch();
`ifdef FIFO_SERIAL_TX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "time limit");
    end

endmodule
